// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the writeback unit.
// The register-file size is selected in the top by YSYX_24120013_RVE_EN.
package ysyx_24120013_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int REG_ZERO = 0;
  localparam int NREG_I   = 32;
  localparam int NREG_E   = 16;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_entry_t;

  // Index reported on commit: entries that do not write report x0.
  function automatic logic [AW-1:0] commit_idx(input wb_entry_t e);
    return e.wen ? e.waddr : AW'(REG_ZERO);
  endfunction

endpackage

// File: rtl/ysyx_24120013_wbu_fifo.sv
// Small result FIFO between execute and writeback. Exposes the head plus every
// slot in age order (index 0 = oldest) with valid bits so the top can search
// pending writes for read bypass.
module ysyx_24120013_wbu_fifo
  import ysyx_24120013_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output wb_entry_t              o_head,
  output wb_entry_t [DEPTH-1:0]  o_entries,
  output logic [DEPTH-1:0]       o_valid
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Age-ordered view of all slots; slot i is live when fewer than r_cnt ahead of it.
  always_comb begin
    o_entries = '0;
    o_valid   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[r_rptr + PW'(i)];
      o_valid[i]   = ((PW+1)'(i) < r_cnt);
    end
  end

endmodule

// File: rtl/ysyx_24120013_wbu.sv
// Writeback unit: buffers execute results, retires one per cycle into the
// general-purpose register file and serves two bypassed read ports.
// Define YSYX_24120013_RVE_EN for a 16-entry RV32E register file; otherwise
// all 32 registers exist.
module ysyx_24120013_wbu
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  commit_valid,
  output logic [ADDR_WIDTH-1:0] commit_waddr,
  output logic [31:0]           commit_cnt
);

`ifdef YSYX_24120013_RVE_EN
  localparam int NREG = NREG_E;
`else
  localparam int NREG = NREG_I;
`endif
  localparam int RW = $clog2(NREG);

  wb_entry_t              w_in_entry;
  wb_entry_t              w_head;
  wb_entry_t [DEPTH-1:0]  w_entries;
  logic [DEPTH-1:0]       w_valid;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head_in_range;
  logic                   w_wr_en;
  logic [ADDR_WIDTH-1:0]  w_raddr [2];
  logic [DATA_WIDTH-1:0]  w_rdata [2];
  logic [1:0]             w_rd_in_range;

  logic [DATA_WIDTH-1:0]  r_regs [NREG];
  logic                   r_commit_valid;
  logic [ADDR_WIDTH-1:0]  r_commit_waddr;
  logic [31:0]            r_commit_cnt;

  assign w_in_entry = '{wen: in_wen, waddr: in_waddr, wdata: in_wdata};
  assign in_ready   = !w_full;
  assign w_push     = in_valid && !w_full;
  assign w_pop      = !stall && !w_empty;

  ysyx_24120013_wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_in_entry),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

`ifdef YSYX_24120013_RVE_EN
  assign w_head_in_range  = (w_head.waddr < ADDR_WIDTH'(NREG));
  assign w_rd_in_range[0] = (raddr1 < ADDR_WIDTH'(NREG));
  assign w_rd_in_range[1] = (raddr2 < ADDR_WIDTH'(NREG));
`else
  assign w_head_in_range  = 1'b1;
  assign w_rd_in_range    = 2'b11;
`endif

  // Out-of-range (RV32E) and x0 writes still retire, they just never land.
  assign w_wr_en = w_pop && w_head.wen && (w_head.waddr != ADDR_WIDTH'(REG_ZERO))
                   && w_head_in_range;

  // Register file; x0 is cleared on reset and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_head.waddr[RW-1:0]] <= w_head.wdata;
    end
  end

  // Commit report: one pulse per retired entry and a free-running retire count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_valid <= 1'b0;
      r_commit_waddr <= '0;
      r_commit_cnt   <= '0;
    end else begin
      r_commit_valid <= w_pop;
      r_commit_waddr <= w_pop ? commit_idx(w_head) : '0;
      if (w_pop) r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  // Read ports: register file, overridden by the newest matching pending write,
  // forced to zero for x0 and for indices outside the implemented file.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_regs[w_raddr[p][RW-1:0]];
      for (int i = 0; i < DEPTH; i++) begin
        if (w_valid[i] && w_entries[i].wen && (w_entries[i].waddr == w_raddr[p]))
          w_rdata[p] = w_entries[i].wdata;
      end
      if ((w_raddr[p] == ADDR_WIDTH'(REG_ZERO)) || !w_rd_in_range[p])
        w_rdata[p] = '0;
    end
  end

  assign rdata1       = w_rdata[0];
  assign rdata2       = w_rdata[1];
  assign commit_valid = r_commit_valid;
  assign commit_waddr = r_commit_waddr;
  assign commit_cnt   = r_commit_cnt;

endmodule

// File: tb/tb_ysyx_24120013_wbu.sv
// Bench for the writeback unit: directed scenarios followed by random traffic,
// checked against a queue-based reference of pending results and a register array.
module tb_ysyx_24120013_wbu;

`ifdef YSYX_24120013_RVE_EN
  localparam int M_NREG = 16;
`else
  localparam int M_NREG = 32;
`endif

  typedef struct {
    bit        wen;
    bit [4:0]  addr;
    bit [31:0] data;
  } m_ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_wdata = '0;
  logic        stall = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        commit_valid;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_cnt;

  int checks = 0;
  int fails  = 0;

  m_ent_t    pend[$];
  bit [31:0] mregs [32];
  bit [31:0] mcnt = '0;
  bit        pop_next = 1'b0;

  ysyx_24120013_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wen       (in_wen),
    .in_waddr     (in_waddr),
    .in_wdata     (in_wdata),
    .stall        (stall),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .commit_valid (commit_valid),
    .commit_waddr (commit_waddr),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] mread(input bit [4:0] a);
    if (a == 5'd0 || int'(a) >= M_NREG) return 32'd0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].wen && pend[i].addr == a) return pend[i].data;
    return mregs[a];
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt     = '0;
    pop_next = 1'b0;
  endtask

  // Monitor: mid-cycle, compare what the last edge produced, then predict the next edge.
  always @(negedge clk) begin
    m_ent_t e;
    if (rst) begin
      if (pop_next) begin
        e = pend.pop_front();
        mcnt = mcnt + 32'd1;
        chk("commit_valid", {31'd0, commit_valid}, 32'd1);
        chk("commit_waddr", {27'd0, commit_waddr}, e.wen ? {27'd0, e.addr} : 32'd0);
        chk("commit_cnt", commit_cnt, mcnt);
        if (e.wen && e.addr != 5'd0 && int'(e.addr) < M_NREG) mregs[e.addr] = e.data;
      end else begin
        chk("commit_idle", {31'd0, commit_valid}, 32'd0);
        chk("commit_cnt_hold", commit_cnt, mcnt);
      end
      chk("in_ready", {31'd0, in_ready}, (pend.size() < 2) ? 32'd1 : 32'd0);
      chk("rdata1", rdata1, mread(raddr1));
      chk("rdata2", rdata2, mread(raddr2));
      pop_next = !stall && (pend.size() > 0);
      if (in_valid && pend.size() < 2) begin
        e.wen  = in_wen;
        e.addr = in_waddr;
        e.data = in_wdata;
        pend.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit wen, input bit [4:0] a, input bit [31:0] d);
    in_valid = 1'b1;
    in_wen   = wen;
    in_waddr = a;
    in_wdata = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL send_timeout actual=no_accept required=accept addr=%0d", a);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (2) cyc();
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_commit_cnt", commit_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    cyc();

    // Single write, retired one cycle after acceptance.
    send(1'b1, 5'd5, 32'h1234);
    repeat (3) cyc();
    raddr1 = 5'd5; #1;
    chk("t1_reg5", rdata1, 32'h1234);
    chk("t1_cnt", commit_cnt, 32'd1);

    // Stalled retirement fills the FIFO; newest pending write wins the bypass.
    stall = 1'b1;
    send(1'b1, 5'd3, 32'hA);
    send(1'b1, 5'd3, 32'hB);
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    raddr1 = 5'd3; #1;
    chk("t2_bypass", rdata1, 32'hB);
    stall = 1'b0;
    repeat (4) cyc();
    chk("t2_reg3", rdata1, 32'hB);
    chk("t2_cnt", commit_cnt, 32'd3);

    // Writes to x0 and non-writing entries are counted but change nothing.
    send(1'b1, 5'd0, 32'hFFFF);
    send(1'b0, 5'd7, 32'h55);
    repeat (4) cyc();
    raddr1 = 5'd0; raddr2 = 5'd7; #1;
    chk("t3_reg0", rdata1, 32'd0);
    chk("t3_reg7", rdata2, 32'd0);
    chk("t3_cnt", commit_cnt, 32'd5);

    // Back-to-back stream.
    for (int i = 0; i < 10; i++) send(1'b1, 5'(6 + i), 32'h100 + 32'(i));
    repeat (4) cyc();
    for (int i = 0; i < 10; i++) begin
      raddr1 = 5'(6 + i); #1;
      chk("t4_stream_reg", rdata1, 32'h100 + 32'(i));
    end
    chk("t4_cnt", commit_cnt, 32'd15);

    // Asynchronous reset with two entries pending.
    stall = 1'b1;
    send(1'b1, 5'd3, 32'h77);
    send(1'b1, 5'd9, 32'h88);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("t5_cnt", commit_cnt, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    raddr1 = 5'd5; raddr2 = 5'd9; #1;
    chk("t5_reg5", rdata1, 32'd0);
    chk("t5_reg9", rdata2, 32'd0);
    model_clear();
    stall = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    raddr1 = 5'd3; #1;
    chk("t5_lost", rdata1, 32'd0);

    // Register index beyond RV32E.
    send(1'b1, 5'd20, 32'h9);
    repeat (3) cyc();
    raddr1 = 5'd20; #1;
`ifdef YSYX_24120013_RVE_EN
    chk("t6_reg20", rdata1, 32'd0);
`else
    chk("t6_reg20", rdata1, 32'h9);
`endif
    chk("t6_cnt", commit_cnt, 32'd1);

    // Random traffic with random stalls and reads.
    for (int n = 0; n < 500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_wen   = $urandom_range(0, 3) != 0;
      in_waddr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      in_wdata = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      raddr1   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      raddr2   = 5'($urandom_range(0, 31));
      cyc();
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
